// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - multiplexed 7-segment bus scanner assembling BCD frames
// One digit is enabled at a time, allowed to settle, then sampled and decoded.
module seg_scan_ctrl #(
    parameter int NUM_DIGITS    = 4,
    parameter int SETTLE_CYCLES = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [6:0]              seg_in,
    output logic [NUM_DIGITS-1:0]   dig_en,
    output logic                    busy,
    output logic [4*NUM_DIGITS-1:0] bcd_out,
    output logic                    err_out,
    output logic                    valid_out,
    input  logic                    ready_in
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        HOLD
    } state_t;

    state_t                    state_q, state_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [NUM_DIGITS-1:0]     dig_en_q, dig_en_d;
    logic [4*NUM_DIGITS-1:0]   bcd_q, bcd_d;
    logic                      err_q, err_d;
    logic                      valid_q, valid_d;
    logic                      busy_q, busy_d;

    logic [3:0]                dec_nib;
    logic                      dec_inv;

    always_comb begin
        dec_nib = 4'd0;
        dec_inv = 1'b0;
        case (seg_in)
            7'b1111110: dec_nib = 4'd0;
            7'b0110000: dec_nib = 4'd1;
            7'b1101101: dec_nib = 4'd2;
            7'b1111001: dec_nib = 4'd3;
            7'b0110011: dec_nib = 4'd4;
            7'b1011011: dec_nib = 4'd5;
            7'b1011111: dec_nib = 4'd6;
            7'b1110000: dec_nib = 4'd7;
            7'b1111111: dec_nib = 4'd8;
            7'b1111011: dec_nib = 4'd9;
            default:    dec_inv = 1'b1;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        dig_en_d = dig_en_q;
        bcd_d    = bcd_q;
        err_d    = err_q;
        valid_d  = valid_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = SETTLE;
                    idx_d    = '0;
                    cnt_d    = '0;
                    dig_en_d = NUM_DIGITS'(1);
                    bcd_d    = '0;
                    err_d    = 1'b0;
                end
            end
            SETTLE: begin
                if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
                    state_d = SAMPLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SAMPLE: begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        bcd_d[4*i +: 4] = dec_nib;
                    end
                end
                err_d = err_q | dec_inv;
                if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
                    state_d  = HOLD;
                    dig_en_d = '0;
                    valid_d  = 1'b1;
                end else begin
                    state_d  = SETTLE;
                    idx_d    = idx_q + 1'b1;
                    cnt_d    = '0;
                    // enable walks upward in step with idx
                    dig_en_d = dig_en_q << 1;
                end
            end
            HOLD: begin
                if (ready_in) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            dig_en_q <= '0;
            bcd_q    <= '0;
            err_q    <= 1'b0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            dig_en_q <= dig_en_d;
            bcd_q    <= bcd_d;
            err_q    <= err_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
        end
    end

    assign dig_en    = dig_en_q;
    assign busy      = busy_q;
    assign bcd_out   = bcd_q;
    assign err_out   = err_q;
    assign valid_out = valid_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - scoreboard bench for seg_scan_ctrl
// A bus model answers dig_en with per-digit patterns; frames are predicted by table lookup.
module tb_seg_scan_ctrl;

    localparam int ND  = 4;
    localparam int SC  = 3;
    localparam int LAT = ND * (SC + 1);

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic            ready_in = 1'b0;
    logic [6:0]      seg_in = 7'h0;
    logic [ND-1:0]   dig_en;
    logic            busy;
    logic [4*ND-1:0] bcd_out;
    logic            err_out;
    logic            valid_out;

    bit clk_en = 1'b1;
    int cyc = 0;
    int n_vec = 0;
    int n_fail = 0;

    typedef struct {
        logic [4*ND-1:0] bcd;
        logic            err;
        int              rise;
    } exp_t;

    exp_t       sb_q[$];
    logic [6:0] pat [ND];
    logic [6:0] seg_tab [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                                 7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};

    seg_scan_ctrl #(.NUM_DIGITS(ND), .SETTLE_CYCLES(SC)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .seg_in    (seg_in),
        .dig_en    (dig_en),
        .busy      (busy),
        .bcd_out   (bcd_out),
        .err_out   (err_out),
        .valid_out (valid_out),
        .ready_in  (ready_in)
    );

    initial forever begin
        #5;
        if (clk_en) clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Frame value = sum of digit * 16^position; unknown patterns flag err and count as 0.
    function automatic exp_t predict(input int rise);
        exp_t x;
        x.bcd  = '0;
        x.err  = 1'b0;
        x.rise = rise;
        for (int d = 0; d < ND; d++) begin
            int v;
            v = -1;
            for (int k = 0; k < 10; k++) if (pat[d] == seg_tab[k]) v = k;
            if (v < 0) x.err = 1'b1;
            else x.bcd = x.bcd + (4*ND)'(v * (1 << (4 * d)));
        end
        return x;
    endfunction

    initial forever begin
        @(negedge clk);
        seg_in = 7'h0;
        for (int d = 0; d < ND; d++) if (dig_en[d]) seg_in = pat[d];
    end

    initial begin
        logic          pv;
        logic [ND-1:0] pd;
        int            ptr;
        exp_t          e;
        pv  = 1'b0;
        pd  = '0;
        ptr = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pv  = 1'b0;
                pd  = '0;
                ptr = 0;
            end else begin
                check("busy_rel", 32'(busy), 32'((dig_en != 0) || valid_out));
                if (dig_en == 0) ptr = 0;
                else if (dig_en != pd) begin
                    check("dig_order", 32'(dig_en), 32'(1 << ptr));
                    ptr++;
                end
                if (valid_out && !pv) begin
                    if (sb_q.size() == 0) begin
                        n_vec++;
                        n_fail++;
                        $display("FAIL unexpected_frame: got valid_out=1, expected no frame (cycle %0d)", cyc);
                    end else begin
                        check("latency", 32'(cyc), 32'(sb_q[0].rise));
                    end
                end
                if (valid_out && ready_in && sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    check("bcd_out", 32'(bcd_out), 32'(e.bcd));
                    check("err_out", 32'(err_out), 32'(e.err));
                end
                pv = valid_out;
                pd = dig_en;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue();
        sb_q.push_back(predict(cyc + 1 + LAT));
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_valid(input int maxc);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            if (valid_out) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) begin
            n_vec++;
            n_fail++;
            $display("FAIL wait_valid: got valid_out=0 for %0d cycles, expected 1", maxc);
        end
    endtask

    task automatic finish_frame(input int dly);
        wait_valid(LAT + 5);
        repeat (dly) tick();
        ready_in = 1'b1;
        tick();
        ready_in = 1'b0;
    endtask

    task automatic rand_pats();
        for (int d = 0; d < ND; d++) begin
            if ($urandom_range(9) == 0) pat[d] = 7'($urandom);
            else pat[d] = seg_tab[$urandom_range(9)];
        end
    endtask

    initial begin
        exp_t e;
        int   first_rise;
        pat = '{7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000};

        repeat (3) @(posedge clk);
        #1;
        check("rst_dig_en", 32'(dig_en), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_bcd", 32'(bcd_out), 0);
        check("rst_err", 32'(err_out), 0);
        check("rst_valid", 32'(valid_out), 0);
        rst = 1'b0;
        tick();

        issue();
        finish_frame(0);

        pat[2] = 7'b0000001;
        issue();
        finish_frame(0);

        rand_pats();
        e = predict(0);
        issue();
        wait_valid(LAT + 5);
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", 32'(valid_out), 1);
            check("hold_bcd", 32'(bcd_out), 32'(e.bcd));
            check("hold_err", 32'(err_out), 32'(e.err));
            start = (i == 2);
            tick();
        end
        start = 1'b0;
        ready_in = 1'b1;
        tick();
        ready_in = 1'b0;
        check("ack_busy", 32'(busy), 0);
        check("ack_valid", 32'(valid_out), 0);
        repeat (3) tick();
        check("hold_start_ignored", 32'(busy), 0);

        rand_pats();
        issue();
        repeat (6) tick();
        clk_en = 1'b0;
        #20;
        rst = 1'b1;
        #1;
        check("async_dig_en", 32'(dig_en), 0);
        check("async_busy", 32'(busy), 0);
        check("async_bcd", 32'(bcd_out), 0);
        check("async_err", 32'(err_out), 0);
        check("async_valid", 32'(valid_out), 0);
        #5;
        rst = 1'b0;
        sb_q.delete();
        clk_en = 1'b1;
        tick();

        rand_pats();
        issue();
        for (int i = 0; i < 20 && dig_en != ND'(2); i++) tick();
        check("reach_digit1", 32'(dig_en), 2);
        rst = 1'b1;
        #1;
        check("midrst_dig_en", 32'(dig_en), 0);
        check("midrst_busy", 32'(busy), 0);
        #1;
        rst = 1'b0;
        sb_q.delete();
        tick();
        for (int d = 0; d < ND; d++) pat[d] = 7'b1111111;
        issue();
        finish_frame(1);

        for (int f = 0; f < 20; f++) begin
            rand_pats();
            issue();
            finish_frame(int'($urandom_range(3)));
        end

        rand_pats();
        first_rise = cyc + 1 + LAT;
        sb_q.push_back(predict(first_rise));
        start = 1'b1;
        ready_in = 1'b1;
        tick();
        wait_valid(LAT + 5);
        rand_pats();
        sb_q.push_back(predict(first_rise + LAT + 2));
        for (int i = 0; i < 5 && valid_out; i++) tick();
        wait_valid(LAT + 5);
        start = 1'b0;
        tick();
        ready_in = 1'b0;
        repeat (3) tick();
        check("sb_drained", 32'(sb_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
